// File: rtl/ati_device_read_packer.sv
// ati_device_read_packer
//   Slave-side read path of the ATI system bus. Bytes are pulled from an
//   attached 8-bit first-word-fall-through device into a byte FIFO, packed
//   little-endian into byte / word / doubleword responses, and driven onto
//   the shared tri-state bus while a read addressed to this channel is pending.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   addr_bus_in         bus address; top CHANNEL_WIDTH bits select the channel
//   rd_req              level read request, held by the master until rd_ack
//   data_type_encode    00 byte, 01 word, 10 doubleword, 11 treated as byte
//   data_bus_out        packed response, Z when this channel is not selected
//   rd_ack              one-cycle response strobe, Z when not selected
//   data_available      FIFO non-empty flag, Z when not selected
//   device_data_in      device head byte
//   device_data_valid   device holds at least one byte
//   device_rd_ins       pop strobe to the device (byte captured on same edge)
module ati_device_read_packer #(
  parameter int                     DATA_BUS_WIDTH    = 64,
  parameter int                     ADDR_BUS_WIDTH    = 64,
  parameter int                     CHANNEL_WIDTH     = 2,
  parameter int                     DATA_TYPE_WIDTH   = 2,
  parameter logic [CHANNEL_WIDTH-1:0] DEVICE_CHANNEL_ID = '0,
  parameter int                     DEVICE_DATA_WIDTH = 8,
  parameter int                     SLAVE_BUFFER_SIZE = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_BUS_WIDTH-1:0]     addr_bus_in,
  input  logic                          rd_req,
  input  logic [DATA_TYPE_WIDTH-1:0]    data_type_encode,
  inout  wire logic [DATA_BUS_WIDTH-1:0] data_bus_out,
  inout  wire logic                     rd_ack,
  inout  wire logic                     data_available,
  input  logic [DEVICE_DATA_WIDTH-1:0]  device_data_in,
  input  logic                          device_data_valid,
  output logic                          device_rd_ins
);

  localparam int PW    = $clog2(SLAVE_BUFFER_SIZE);
  localparam int LANES = DATA_BUS_WIDTH / DEVICE_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                        state;
  logic [DEVICE_DATA_WIDTH-1:0]  mem [SLAVE_BUFFER_SIZE];
  logic [PW-1:0]                 front;
  logic [PW-1:0]                 rear;
  logic [PW:0]                   count;
  logic [3:0]                    n_reg;
  logic [DATA_BUS_WIDTH-1:0]     packed_word;

  logic                          sel;
  logic                          push;
  logic [3:0]                    n_cur;
  logic [PW:0]                   n_ext;
  logic [DATA_BUS_WIDTH-1:0]     packed_next;
  logic [PW-1:0]                 idx;
  logic                          unused_addr_bits;

  assign sel  = (addr_bus_in[ADDR_BUS_WIDTH-1 -: CHANNEL_WIDTH] == DEVICE_CHANNEL_ID);
  assign push = device_data_valid & (count < (PW+1)'(SLAVE_BUFFER_SIZE)) & rst_n;
  assign device_rd_ins = push;
  assign unused_addr_bits = ^addr_bus_in[ADDR_BUS_WIDTH-CHANNEL_WIDTH-1:0];

  always_comb begin
    case (data_type_encode)
      DATA_TYPE_WIDTH'(1): n_cur = 4'd4;
      DATA_TYPE_WIDTH'(2): n_cur = 4'd8;
      default:             n_cur = 4'd1;
    endcase
  end

  assign n_ext = (PW+1)'(n_cur);

  // Lanes at or above the request size stay zero; indices wrap with the pointer width.
  always_comb begin
    packed_next = '0;
    idx         = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      idx = front + PW'(i);
      if (i < 32'(n_cur))
        packed_next[i*DEVICE_DATA_WIDTH +: DEVICE_DATA_WIDTH] = mem[idx];
    end
  end

  // Storage is not reset: contents are discarded logically via the pointers.
  always_ff @(posedge clk) begin
    if (push)
      mem[rear] <= device_data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      front       <= '0;
      rear        <= '0;
      count       <= '0;
      n_reg       <= 4'd1;
      packed_word <= '0;
    end else begin
      if (push)
        rear <= rear + PW'(1);
      // Pop amount is the size latched on RESP entry; push uses registered count only.
      count <= count + (PW+1)'(push)
             - ((state == ST_RESP) ? (PW+1)'(n_reg) : '0);
      case (state)
        ST_IDLE: begin
          if (sel && rd_req) begin
            if (count >= n_ext) begin
              state       <= ST_RESP;
              n_reg       <= n_cur;
              packed_word <= packed_next;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!rd_req || !sel) begin
            state <= ST_IDLE;
          end else if (count >= n_ext) begin
            state       <= ST_RESP;
            n_reg       <= n_cur;
            packed_word <= packed_next;
          end
        end
        ST_RESP: begin
          front <= front + PW'(n_reg);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_bus_out   = sel ? packed_word : 'z;
  assign rd_ack         = sel ? (state == ST_RESP) : 1'bz;
  assign data_available = sel ? (count != '0) : 1'bz;

endmodule
